// File: rtl/count_pkg.sv
// Shared types and helpers for the count-stream monitor.
package count_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FIRST = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } monitor_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Increment that holds at the all-ones value of a 'width'-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with clear and load-one controls (clear wins, then load, then increment).
module sat_counter
    import count_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load_one,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load_one) begin
            count <= WIDTH'(1);
        end else if (inc) begin
            count <= WIDTH'(sat_inc(32'(count), WIDTH));
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Observes an up/down counter's output bus and recovers direction, wraps,
// illegal steps and the current run length. NBITS must be at least 2.
module count_monitor
    import count_pkg::*;
#(
    parameter int unsigned NBITS    = 4,
    parameter int unsigned RUN_BITS = 8,
    parameter int unsigned ERR_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [NBITS-1:0]    count_in,
    output logic                dir_out,
    output logic                dir_valid,
    output logic                wrap_pulse,
    output logic                step_err,
    output logic [RUN_BITS-1:0] run_len,
    output logic [ERR_BITS-1:0] err_count
);

    monitor_state_t   state_q, state_d;
    logic [NBITS-1:0] prev_q, prev_d;
    logic [NBITS-1:0] delta;
    logic             step_up, step_dn;
    logic             dir_d, dir_valid_d, wrap_d, err_d;
    logic             run_clr, run_load, run_inc, err_inc;

    // Modulo-2^NBITS difference; +1 and -1 are the only legal steps.
    assign delta   = count_in - prev_q;
    assign step_up = (delta == NBITS'(1));
    assign step_dn = (delta == {NBITS{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            prev_q     <= '0;
            dir_out    <= DIR_UP;
            dir_valid  <= 1'b0;
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            dir_out    <= dir_d;
            dir_valid  <= dir_valid_d;
            wrap_pulse <= wrap_d;
            step_err   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dir_d       = dir_out;
        dir_valid_d = dir_valid;
        wrap_d      = 1'b0;
        err_d       = 1'b0;
        run_clr     = 1'b0;
        run_load    = 1'b0;
        run_inc     = 1'b0;
        err_inc     = 1'b0;

        if (valid_in) begin
            prev_d = count_in;
            if (state_q == EMPTY) begin
                state_d = FIRST;
            end else if (step_up) begin
                state_d     = UP;
                dir_d       = DIR_UP;
                dir_valid_d = 1'b1;
                run_inc     = (state_q == UP);
                run_load    = (state_q != UP);
                wrap_d      = (prev_q == {NBITS{1'b1}}) && (count_in == '0);
            end else if (step_dn) begin
                state_d     = DOWN;
                dir_d       = DIR_DOWN;
                dir_valid_d = 1'b1;
                run_inc     = (state_q == DOWN);
                run_load    = (state_q != DOWN);
                wrap_d      = (prev_q == '0) && (count_in == {NBITS{1'b1}});
            end else if (delta != '0) begin
                // Arbitrary jump: resynchronise on this sample, keep last direction.
                state_d     = FIRST;
                dir_valid_d = 1'b0;
                err_d       = 1'b1;
                err_inc     = 1'b1;
                run_clr     = 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(RUN_BITS)) u_run_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (run_clr),
        .load_one (run_load),
        .inc      (run_inc),
        .count    (run_len)
    );

    sat_counter #(.WIDTH(ERR_BITS)) u_err_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (1'b0),
        .load_one (1'b0),
        .inc      (err_inc),
        .count    (err_count)
    );

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Observer for the up/down counter's output bus: samples the NBITS count stream and recovers what the counter is doing.
- Recovered information: count direction (same encoding as the counter's select input: 1 = up, 0 = down), wrap-around events, illegal steps, and current run length.
- Sits beside the counter in the datapath as the checker/decoder end of the count interface.
- Purely synchronous to the counter's clock.

Parameters:
- NBITS, 4, width of the observed count; must be >= 2, because +1 and -1 are indistinguishable at width 1.
- RUN_BITS, 8, width of the run-length counter, saturating.
- ERR_BITS, 8, width of the illegal-step counter, saturating.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  count_in is sampled on this cycle
- count_in  in  NBITS  observed counter value
- dir_out  out  1  recovered direction: 1 = up, 0 = down
- dir_valid  out  1  dir_out is meaningful (state UP or DOWN)
- wrap_pulse  out  1  one-cycle pulse: last accepted step wrapped max->0 or 0->max
- step_err  out  1  one-cycle pulse: last accepted sample was an illegal step
- run_len  out  RUN_BITS  consecutive legal steps in the current direction
- err_count  out  ERR_BITS  total illegal steps since reset

Behaviour:
- Reset, while reset==0, asynchronous:
  - state = EMPTY, prev = 0
  - dir_out = 1, dir_valid = 0, wrap_pulse = 0, step_err = 0, run_len = 0, err_count = 0
- Update timing: registers change only on rising clk edges where valid_in==1. Outputs are registered, so latency is 1 cycle from the sampling edge.
- Pulse outputs: wrap_pulse and step_err clear on any edge that does not assert them, including edges with valid_in==0.
- delta = (count_in - prev), computed modulo 2^NBITS in NBITS-bit arithmetic; no widening.
- FSM states: EMPTY, FIRST, UP, DOWN.
- EMPTY:
  - valid_in -> prev = count_in, go to FIRST.
  - No flags; run_len stays 0.
- FIRST, UP, DOWN, on valid_in:
  - delta==0: stall. Nothing changes except prev, which is rewritten with the same value.
  - delta==1:
    - go to UP, dir_out = 1, dir_valid = 1.
    - If previous state was UP: run_len = sat(run_len+1). Otherwise run_len = 1.
  - delta==all-ones (i.e. -1):
    - go to DOWN, dir_out = 0, dir_valid = 1.
    - If previous state was DOWN: run_len = sat(run_len+1). Otherwise run_len = 1.
  - Any other delta:
    - step_err = 1, err_count = sat(err_count+1).
    - go to FIRST, dir_valid = 0, run_len = 0; dir_out holds its last value.
  - prev = count_in in every case.
- wrap_pulse = 1 when a legal step satisfies either:
  - delta==1 with prev==2^NBITS-1 and count_in==0, or
  - delta==-1 with prev==0 and count_in==2^NBITS-1.
- Direction reversal (UP->DOWN or DOWN->UP) is legal: no step_err, run_len restarts at 1.
- A reversal step that crosses the boundary also asserts wrap_pulse.
- Saturation: run_len and err_count hold at all-ones; they never wrap.
- Counter reset to zero: the counter's up-mode reset to 0 (or down-mode reset to max) appears as an arbitrary jump. It is flagged as step_err, unless it happens to be a ±1 step.
- Reset mid-operation: returns immediately to the reset values above; the next valid sample is treated as the first.
- valid_in==0: all state holds; pulses drop to 0.

Decomposition:
- Shared package count_pkg:
  - state enum (EMPTY, FIRST, UP, DOWN) as typedef monitor_state_t
  - localparam DIR_UP=1'b1, DIR_DOWN=1'b0
  - function sat_inc, parameterised by width through the call site
- One natural sub-module: sat_counter (WIDTH parameter; inputs clr, load_one, inc; saturating). Instantiated twice, for run_len and err_count.

Test Plan:
- Reset then valid samples 3,4,5,6 -> after sample 4, dir_out=1, dir_valid=1, run_len=1; after sample 6, run_len=3; step_err never asserted.
- Samples 14,15,0,1 (NBITS=4) -> wrap_pulse high exactly one cycle after sampling 0; run_len=3 after sample 1; dir_out=1.
- Samples 1,0,15,14 -> dir_out=0, wrap_pulse one cycle after sampling 15, run_len=3; then sample 15 -> reversal, dir_out=1, run_len=1, no step_err.
- Samples 5,6,9 -> step_err pulse after 9, err_count=1, dir_valid=0, run_len=0; then sample 10 -> UP, run_len=1, dir_valid=1.
- Samples 7,7,valid_in=0 for 3 cycles,8 -> repeated 7 ignored, no state change while idle; after 8, dir_out=1, run_len=1.
- Mid-run (run_len=5) drive reset low between clock edges -> outputs go to reset values immediately; release, sample 2 then 3 -> dir_valid only after 3; with RUN_BITS=2, 5 up steps -> run_len saturates at 3.
